// File: rtl/chroma_upsample_stream_if.sv
// Block-stream handshake bundle for the chroma upsampler: one input block stream
// and one upsampled output block stream, each with valid/ready.
interface chroma_upsample_stream_if #(
  parameter int DW   = 9,
  parameter int N    = 8,
  parameter int CH_W = 2
);
  logic                           in_valid;
  logic                           in_ready;
  logic [CH_W-1:0]                in_ch;
  logic [1:0]                     in_mode;
  logic [N-1:0][N-1:0][DW-1:0]    in_block;
  logic                           out_valid;
  logic                           out_ready;
  logic [N-1:0][N-1:0][DW-1:0]    out_block;
  logic [1:0]                     out_idx;
  logic                           out_last;
  logic [CH_W-1:0]                out_ch;

  modport slave (
    input  in_valid, in_ch, in_mode, in_block, out_ready,
    output in_ready, out_valid, out_block, out_idx, out_last, out_ch
  );

  modport master (
    output in_valid, in_ch, in_mode, in_block, out_ready,
    input  in_ready, out_valid, out_block, out_idx, out_last, out_ch
  );
endinterface

// File: rtl/chroma_upsample_stream.sv
// Nearest-neighbour chroma upsampler: buffers one NxN block and replays it as
// 1 (4:4:4), 2 (4:2:2) or 4 (4:2:0) full-resolution blocks, one per cycle.
module chroma_upsample_stream #(
  parameter int DW   = 9,
  parameter int N    = 8,
  parameter int CH_W = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  chroma_upsample_stream_if.slave bus
);
  localparam int H  = N / 2;
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, EMIT} state_t;
  typedef logic [N-1:0][N-1:0][DW-1:0] blk_t;

  state_t     state;
  blk_t       buf_blk;
  logic [1:0] mode_q;
  logic [1:0] eff_mode;
  logic       accept;
  logic       advance;

  function automatic logic [1:0] last_idx(input logic [1:0] mode);
    case (mode)
      2'b01:   return 2'd1;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // idx[0] selects the right half, idx[1] the bottom half (4:2:0 only).
  function automatic blk_t upsample(input blk_t src, input logic [1:0] mode,
                                    input logic [1:0] idx);
    blk_t        o;
    int unsigned ri;
    int unsigned ci;
    o = '0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        case (mode)
          2'b01: begin
            ri = r;
            ci = idx[0] ? H + c / 2 : c / 2;
          end
          2'b10: begin
            ri = idx[1] ? H + r / 2 : r / 2;
            ci = idx[0] ? H + c / 2 : c / 2;
          end
          default: begin
            ri = r;
            ci = c;
          end
        endcase
        o[IW'(r)][IW'(c)] = src[IW'(ri)][IW'(ci)];
      end
    end
    return o;
  endfunction

  always_comb begin
    eff_mode     = (bus.in_ch == '0 || bus.in_mode == 2'b11) ? 2'b00 : bus.in_mode;
    advance      = bus.out_valid && bus.out_ready;
    bus.in_ready = (state == IDLE) || (advance && bus.out_last);
    accept       = bus.in_valid && bus.in_ready;
  end

  // Accept takes priority: on a last-beat handoff it both retires the old block
  // and loads idx 0 of the new one, so the old last beat is never repeated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      buf_blk       <= '0;
      mode_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_block <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_ch    <= '0;
    end else if (accept) begin
      state         <= EMIT;
      buf_blk       <= bus.in_block;
      mode_q        <= eff_mode;
      bus.out_valid <= 1'b1;
      bus.out_block <= upsample(bus.in_block, eff_mode, 2'd0);
      bus.out_idx   <= '0;
      bus.out_last  <= (last_idx(eff_mode) == 2'd0);
      bus.out_ch    <= bus.in_ch;
    end else if (state == EMIT && advance) begin
      if (!bus.out_last) begin
        bus.out_idx   <= bus.out_idx + 2'd1;
        bus.out_block <= upsample(buf_blk, mode_q, bus.out_idx + 2'd1);
        bus.out_last  <= (bus.out_idx + 2'd1 == last_idx(mode_q));
      end else begin
        state         <= IDLE;
        bus.out_valid <= 1'b0;
        bus.out_block <= '0;
        bus.out_idx   <= '0;
        bus.out_last  <= 1'b0;
        bus.out_ch    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_chroma_upsample_stream.sv
// Directed bench for chroma_upsample_stream: 4:2:0, 4:2:2, passthrough,
// back-pressure, back-to-back handoff and asynchronous reset mid-burst.
module tb_chroma_upsample_stream;
  localparam int DW   = 9;
  localparam int N    = 8;
  localparam int CH_W = 2;
  typedef logic [N-1:0][N-1:0][DW-1:0] blk_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  blk_t ramp;
  blk_t ones;

  chroma_upsample_stream_if #(.DW(DW), .N(N), .CH_W(CH_W)) bus ();
  chroma_upsample_stream #(.DW(DW), .N(N), .CH_W(CH_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input blk_t exp);
    vectors++;
    assert (bus.out_block === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, bus.out_block[0], exp[0]);
    end
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [1:0] idx,
                          input logic last, input logic [1:0] ch);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".idx"},   32'(bus.out_idx),   32'(idx));
    chk({tag, ".last"},  32'(bus.out_last),  32'(last));
    chk({tag, ".ch"},    32'(bus.out_ch),    32'(ch));
  endtask

  task automatic chk_row(input string tag, input int r, input int e[8]);
    for (int c = 0; c < N; c++)
      chk($sformatf("%s[%0d][%0d]", tag, r, c), 32'(bus.out_block[r][c]), e[c]);
  endtask

  task automatic chk_px(input string tag, input int r, input int c, input int e);
    chk($sformatf("%s[%0d][%0d]", tag, r, c), 32'(bus.out_block[r][c]), e);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk_blk({tag, ".blk"}, '0);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [1:0] ch, input logic [1:0] mode, input blk_t b);
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_mode  = mode;
    bus.in_block = b;
  endtask

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        ramp[r][c] = DW'(8 * r + c);
    ones = '1;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_mode   = '0;
    bus.in_block  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk_idle("rst");
    chk_beat("rst", 1'b0, 2'd0, 1'b0, 2'd0);
    reset = 1'b0;

    // 1: 4:2:0 ramp, Cb
    offer(2'd1, 2'b10, ramp);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk_beat("t1.i0", 1'b1, 2'd0, 1'b0, 2'd1);
    chk("t1.i0.in_ready", 32'(bus.in_ready), 32'd0);
    chk_row("t1.i0", 0, '{0, 0, 1, 1, 2, 2, 3, 3});
    chk_px("t1.i0", 2, 0, 8);
    chk_px("t1.i0", 7, 7, 27);
    step();
    chk_beat("t1.i1", 1'b1, 2'd1, 1'b0, 2'd1);
    chk_px("t1.i1", 0, 0, 4);
    chk_px("t1.i1", 7, 7, 31);
    step();
    chk_beat("t1.i2", 1'b1, 2'd2, 1'b0, 2'd1);
    chk_px("t1.i2", 0, 0, 32);
    chk_px("t1.i2", 7, 7, 59);
    step();
    chk_beat("t1.i3", 1'b1, 2'd3, 1'b1, 2'd1);
    chk_px("t1.i3", 0, 0, 36);
    chk_px("t1.i3", 7, 7, 63);
    chk("t1.i3.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk_idle("t1.end");

    // 2: 4:2:2 ramp, Cr
    offer(2'd2, 2'b01, ramp);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk_beat("t2.i0", 1'b1, 2'd0, 1'b0, 2'd2);
    chk_row("t2.i0", 0, '{0, 0, 1, 1, 2, 2, 3, 3});
    step();
    chk_beat("t2.i1", 1'b1, 2'd1, 1'b1, 2'd2);
    chk_row("t2.i1", 0, '{4, 4, 5, 5, 6, 6, 7, 7});
    chk_row("t2.i1", 7, '{60, 60, 61, 61, 62, 62, 63, 63});
    step();
    chk_idle("t2.end");

    // 3: luma ignores 4:2:0 request; reserved mode behaves as 4:4:4
    offer(2'd0, 2'b10, ramp);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk_beat("t3a", 1'b1, 2'd0, 1'b1, 2'd0);
    chk_blk("t3a.blk", ramp);
    step();
    chk_idle("t3a.end");
    offer(2'd1, 2'b11, ramp);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk_beat("t3b", 1'b1, 2'd0, 1'b1, 2'd1);
    chk_blk("t3b.blk", ramp);
    step();
    chk_idle("t3b.end");

    // 4: back-pressure held on 4:2:0 idx1
    offer(2'd1, 2'b10, ramp);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk_beat("t4.i0", 1'b1, 2'd0, 1'b0, 2'd1);
    step();
    bus.out_ready = 1'b0;
    #1;
    chk_beat("t4.i1", 1'b1, 2'd1, 1'b0, 2'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_beat($sformatf("t4.hold%0d", k), 1'b1, 2'd1, 1'b0, 2'd1);
      chk_px($sformatf("t4.hold%0d", k), 0, 0, 4);
      chk_px($sformatf("t4.hold%0d", k), 7, 7, 31);
      chk($sformatf("t4.hold%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk_beat("t4.i2", 1'b1, 2'd2, 1'b0, 2'd1);
    chk_px("t4.i2", 0, 0, 32);
    step();
    chk_beat("t4.i3", 1'b1, 2'd3, 1'b1, 2'd1);
    chk_px("t4.i3", 0, 0, 36);
    step();
    chk_idle("t4.end");

    // 5: back-to-back 4:2:0 blocks, B taken on A's last handshake
    offer(2'd1, 2'b10, ramp);
    step();
    bus.in_block = ones;
    #1;
    chk_beat("t5.a0", 1'b1, 2'd0, 1'b0, 2'd1);
    chk("t5.a0.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk_beat("t5.a1", 1'b1, 2'd1, 1'b0, 2'd1);
    step();
    chk_beat("t5.a2", 1'b1, 2'd2, 1'b0, 2'd1);
    step();
    chk_beat("t5.a3", 1'b1, 2'd3, 1'b1, 2'd1);
    chk_px("t5.a3", 0, 0, 36);
    chk("t5.a3.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk_beat("t5.b0", 1'b1, 2'd0, 1'b0, 2'd1);
    chk_blk("t5.b0.blk", ones);
    chk_px("t5.b0", 0, 0, 9'h1FF);
    step();
    chk_beat("t5.b1", 1'b1, 2'd1, 1'b0, 2'd1);
    chk_blk("t5.b1.blk", ones);
    step();
    chk_beat("t5.b2", 1'b1, 2'd2, 1'b0, 2'd1);
    step();
    chk_beat("t5.b3", 1'b1, 2'd3, 1'b1, 2'd1);
    chk_blk("t5.b3.blk", ones);
    step();
    chk_idle("t5.end");

    // 6: asynchronous reset while idx = 2
    offer(2'd1, 2'b10, ramp);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk_beat("t6.i2", 1'b1, 2'd2, 1'b0, 2'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("t6.rst");
    chk_beat("t6.rst", 1'b0, 2'd0, 1'b0, 2'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle($sformatf("t6.after%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
